trace_monitor: RTL

TRACE_MONITOR -- requirements
Module: trace_monitor

---
 rtl/trace_monitor.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/trace_monitor.sv
`default_nettype none
// ============================================================================
// Module   : trace_monitor
// Purpose  : Runs a CPU under test through reset and run phases and records
//            the most recent DEPTH retired instructions in a circular trace
//            buffer. A run ends when the same PC retires HALT_REPEAT times in
//            a row (halt) or when MAX_CYCLES run cycles have elapsed
//            (timeout). The trace is read back oldest-first while idle/done.
// Ports    : clk        - clock, rising edge
//            rstn       - asynchronous active-low reset
//            start      - begin a run (sampled in IDLE/DONE)
//            valid      - CPU retired an instruction this cycle
//            pc, instr  - PC and instruction word of the retired instruction
//            rd_en      - pop one trace entry
//            cpu_rstn   - registered active-low reset to the CPU
//            rd_data    - {pc,instr} of the popped entry
//            rd_valid   - rd_data valid (one cycle per pop)
//            count      - entries held in the trace buffer
//            cycle_cnt  - run cycles elapsed
//            state      - IDLE=0, RESET=1, RUN=2, DONE=3
//            halted     - run ended by halt detection
//            timeout    - run ended by cycle budget
// Revision : 1.0 - initial release
// ============================================================================
module trace_monitor #(
    parameter int PC_W        = 32,
    parameter int INSTR_W     = 32,
    parameter int DEPTH       = 16,
    parameter int MAX_CYCLES  = 250,
    parameter int HALT_REPEAT = 4,
    parameter int RST_CYCLES  = 2
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    start,
    input  logic                    valid,
    input  logic [PC_W-1:0]         pc,
    input  logic [INSTR_W-1:0]      instr,
    input  logic                    rd_en,
    output logic                    cpu_rstn,
    output logic [PC_W+INSTR_W-1:0] rd_data,
    output logic                    rd_valid,
    output logic [$clog2(DEPTH):0]  count,
    output logic [31:0]             cycle_cnt,
    output logic [1:0]              state,
    output logic                    halted,
    output logic                    timeout
);

    localparam int c_ADDR_W = $clog2(DEPTH);
    localparam int c_CNT_W  = c_ADDR_W + 1;
    localparam int c_DATA_W = PC_W + INSTR_W;
    localparam int c_REP_W  = $clog2(HALT_REPEAT + 1);
    localparam int c_RST_W  = $clog2(RST_CYCLES + 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_RESET = 2'd1;
    localparam logic [1:0] c_RUN   = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    // ------------------------------------------------------------------------
    // State and bookkeeping registers
    // ------------------------------------------------------------------------
    logic [1:0]          r_state;
    logic                r_cpu_rstn;
    logic [c_DATA_W-1:0] r_rd_data;
    logic                r_rd_valid;
    logic [c_CNT_W-1:0]  r_count;
    logic [c_ADDR_W-1:0] r_wptr;
    logic [c_ADDR_W-1:0] r_rptr;
    logic [31:0]         r_cycle_cnt;
    logic                r_halted;
    logic                r_timeout;
    logic [c_REP_W-1:0]  r_repeat;
    logic [PC_W-1:0]     r_last_pc;
    logic [c_RST_W-1:0]  r_rst_cnt;

    // Trace storage is deliberately left out of reset; pointers and count
    // define which entries are meaningful.
    logic [c_DATA_W-1:0] r_mem [DEPTH];

    logic [1:0]          w_next_state;
    logic                w_wr_en;
    logic [c_REP_W-1:0]  w_rep_next;
    logic                w_halt_now;
    logic                w_budget_end;
    logic                w_rd_fire;
    logic                w_enter_reset;
    logic                w_full;

    // ------------------------------------------------------------------------
    // Next-state and qualifier logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_wr_en      = (r_state == c_RUN) && valid;
        w_full       = (r_count == c_CNT_W'(DEPTH));
        w_rep_next   = r_repeat;
        // A zero repeat count marks "no retire yet this run", so the cleared
        // last_pc value cannot masquerade as a previous retire of PC 0.
        if (w_wr_en) begin
            if ((pc == r_last_pc) && (r_repeat != '0)) begin
                w_rep_next = r_repeat + c_REP_W'(1);
            end else begin
                w_rep_next = c_REP_W'(1);
            end
        end
        w_halt_now   = w_wr_en && (w_rep_next == c_REP_W'(HALT_REPEAT));
        w_budget_end = (r_state == c_RUN) && ((r_cycle_cnt + 32'd1) == 32'(MAX_CYCLES));
        w_rd_fire    = rd_en && ((r_state == c_IDLE) || (r_state == c_DONE))
                       && (r_count != '0);

        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (start) w_next_state = c_RESET;
            c_RESET: if (r_rst_cnt == c_RST_W'(RST_CYCLES - 1)) w_next_state = c_RUN;
            c_RUN:   if (w_halt_now || w_budget_end) w_next_state = c_DONE;
            c_DONE:  if (start) w_next_state = c_RESET;
            default: w_next_state = c_IDLE;
        endcase

        w_enter_reset = (w_next_state == c_RESET) && (r_state != c_RESET);
    end

    // ------------------------------------------------------------------------
    // State register and datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= c_IDLE;
            r_cpu_rstn  <= 1'b0;
            r_rd_data   <= '0;
            r_rd_valid  <= 1'b0;
            r_count     <= '0;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_cycle_cnt <= '0;
            r_halted    <= 1'b0;
            r_timeout   <= 1'b0;
            r_repeat    <= '0;
            r_last_pc   <= '0;
            r_rst_cnt   <= '0;
        end else begin
            r_state    <= w_next_state;
            // Registered from the next state so cpu_rstn is high exactly
            // while state reads RUN.
            r_cpu_rstn <= (w_next_state == c_RUN);
            r_rd_valid <= w_rd_fire;

            if (w_rd_fire) begin
                r_rd_data <= r_mem[r_rptr];
                r_rptr    <= r_rptr + c_ADDR_W'(1);
                r_count   <= r_count - c_CNT_W'(1);
            end

            if (w_enter_reset) begin
                // Placed after the read update so a new run always starts
                // from an empty trace.
                r_count     <= '0;
                r_wptr      <= '0;
                r_rptr      <= '0;
                r_cycle_cnt <= '0;
                r_halted    <= 1'b0;
                r_timeout   <= 1'b0;
                r_repeat    <= '0;
                r_last_pc   <= '0;
                r_rst_cnt   <= '0;
            end else if (r_state == c_RESET) begin
                r_rst_cnt <= r_rst_cnt + c_RST_W'(1);
            end else if (r_state == c_RUN) begin
                r_cycle_cnt <= r_cycle_cnt + 32'd1;
                if (w_wr_en) begin
                    r_wptr    <= r_wptr + c_ADDR_W'(1);
                    r_last_pc <= pc;
                    r_repeat  <= w_rep_next;
                    // When full, the write lands on the oldest entry, so the
                    // read pointer moves past it and the count saturates.
                    if (w_full) begin
                        r_rptr <= r_rptr + c_ADDR_W'(1);
                    end else begin
                        r_count <= r_count + c_CNT_W'(1);
                    end
                end
                // Halt takes priority when both end conditions coincide.
                if (w_halt_now) begin
                    r_halted <= 1'b1;
                end else if (w_budget_end) begin
                    r_timeout <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wptr] <= {pc, instr};
        end
    end

    assign cpu_rstn  = r_cpu_rstn;
    assign rd_data   = r_rd_data;
    assign rd_valid  = r_rd_valid;
    assign count     = r_count;
    assign cycle_cnt = r_cycle_cnt;
    assign state     = r_state;
    assign halted    = r_halted;
    assign timeout   = r_timeout;

endmodule
`default_nettype wire
